// File: rtl/memory_map_pkg.sv
// Shared memory-map constants and FSM encoding for the CPU memory responder.
// The I/O window starts at IO_BASE. Switches and LEDs sit at fixed offsets from it.
package memory_map_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE    = 2'd0,
        STATE_ACCESS  = 2'd1,
        STATE_RESPOND = 2'd2
    } state_e;

    localparam logic [15:0] IO_BASE_DEFAULT  = 16'hFF00;
    localparam logic [15:0] IO_SWITCH_OFFSET = 16'h0000;
    localparam logic [15:0] IO_LED_OFFSET    = 16'h0001;
    localparam logic [15:0] READ_DATA_NONE   = 16'h0000;

endpackage

// File: rtl/memory_responder_if.sv
// Request/response bundle between the CPU (master) and the memory responder (slave).
// The request side uses valid/ready. The response is a single-cycle pulse with no backpressure.
interface memory_responder_if;
    logic        request_valid;
    logic        request_ready;
    logic        request_write;
    logic [15:0] request_address;
    logic [15:0] request_write_data;
    logic        response_valid;
    logic [15:0] response_read_data;

    modport master (
        output request_valid, request_write, request_address, request_write_data,
        input  request_ready, response_valid, response_read_data
    );

    modport slave (
        input  request_valid, request_write, request_address, request_write_data,
        output request_ready, response_valid, response_read_data
    );
endinterface

// File: rtl/ram_single_port.sv
// Single-port word RAM with a synchronous write and a registered read, for block-RAM inference.
// One-cycle read latency. A read issued in the same cycle as a write returns the old contents.
module ram_single_port #(
    parameter int DEPTH_LOG2 = 10,
    parameter int WIDTH      = 16
) (
    input  logic                  clock,
    input  logic                  write_enable,
    input  logic [DEPTH_LOG2-1:0] address,
    input  logic [WIDTH-1:0]      write_data,
    output logic [WIDTH-1:0]      read_data
);
    logic [WIDTH-1:0] mem [0:(2**DEPTH_LOG2)-1];

    always_ff @(posedge clock) begin
        if (write_enable) begin
            mem[address] <= write_data;
        end
        read_data <= mem[address];
    end
endmodule

// File: rtl/memory_responder.sv
// Services one RAM or I/O read/write at a time. The response pulse comes READ_LATENCY cycles after acceptance.
// Ready is high only in IDLE, so a new request waits until the previous response pulse has ended.
module memory_responder
    import memory_map_pkg::*;
#(
    parameter int          DEPTH_LOG2   = 10,
    parameter int          READ_LATENCY = 1,
    parameter logic [15:0] IO_BASE      = IO_BASE_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    memory_responder_if.slave   bus,
    input  logic [15:0]         io_input,
    output logic [15:0]         io_output,
    output logic                error
);
    localparam logic [16:0] RAM_WORDS = 17'(2**DEPTH_LOG2);
    localparam logic [2:0]  LAT_INIT  = 3'(READ_LATENCY - 1);

    state_e      state_q, state_d;
    logic [2:0]  count_q, count_d;
    logic        req_write_q, req_write_d;
    logic [15:0] req_addr_q, req_addr_d;
    logic [15:0] req_wdata_q, req_wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] io_out_q, io_out_d;
    logic        error_q, error_d;
    logic [15:0] sync1_q, sync2_q;

    logic                  accept, commit, in_ram, in_io, ram_we;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [15:0]           ram_rdata;

    assign bus.request_ready      = (state_q == STATE_IDLE) && reset;
    assign bus.response_valid     = (state_q == STATE_RESPOND);
    assign bus.response_read_data = rdata_q;
    assign io_output              = io_out_q;
    assign error                  = error_q;

    assign accept = bus.request_valid && bus.request_ready;
    assign commit = (state_q == STATE_ACCESS) && (count_q == 3'd0);
    assign in_ram = {1'b0, req_addr_q} < RAM_WORDS;
    assign in_io  = req_addr_q >= IO_BASE;
    assign ram_we = commit && req_write_q && in_ram;
    // Present the incoming address while idle so read data is ready by the first ACCESS cycle.
    assign ram_addr = (state_q == STATE_IDLE) ? bus.request_address[DEPTH_LOG2-1:0]
                                              : req_addr_q[DEPTH_LOG2-1:0];

    ram_single_port #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(16)) u_ram (
        .clock       (clock),
        .write_enable(ram_we),
        .address     (ram_addr),
        .write_data  (req_wdata_q),
        .read_data   (ram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        req_write_d = req_write_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        rdata_d     = rdata_q;
        io_out_d    = io_out_q;
        error_d     = error_q;
        case (state_q)
            STATE_IDLE: begin
                if (accept) begin
                    req_write_d = bus.request_write;
                    req_addr_d  = bus.request_address;
                    req_wdata_d = bus.request_write_data;
                    count_d     = LAT_INIT;
                    state_d     = STATE_ACCESS;
                end
            end
            STATE_ACCESS: begin
                if (count_q == 3'd0) begin
                    state_d = STATE_RESPOND;
                    rdata_d = READ_DATA_NONE;
                    if (in_ram) begin
                        if (!req_write_q) rdata_d = ram_rdata;
                    end else if (req_addr_q == IO_BASE + IO_SWITCH_OFFSET) begin
                        if (!req_write_q) rdata_d = sync2_q;
                    end else if (req_addr_q == IO_BASE + IO_LED_OFFSET) begin
                        if (req_write_q) io_out_d = req_wdata_q;
                        else             rdata_d  = io_out_q;
                    end else if (!in_io) begin
                        error_d = 1'b1;
                    end
                end else begin
                    count_d = count_q - 3'd1;
                end
            end
            STATE_RESPOND: state_d = STATE_IDLE;
            default:       state_d = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= STATE_IDLE;
            count_q     <= 3'd0;
            req_write_q <= 1'b0;
            req_addr_q  <= 16'h0000;
            req_wdata_q <= 16'h0000;
            rdata_q     <= READ_DATA_NONE;
            io_out_q    <= 16'h0000;
            error_q     <= 1'b0;
            sync1_q     <= 16'h0000;
            sync2_q     <= 16'h0000;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            req_write_q <= req_write_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            rdata_q     <= rdata_d;
            io_out_q    <= io_out_d;
            error_q     <= error_d;
            sync1_q     <= io_input;
            sync2_q     <= sync1_q;
        end
    end
endmodule

// File: doc/memory_responder.md
Name: memory_responder

Overview:
- Memory-side responder for the CPU datapath's 16-bit word-addressed memory interface.
- Accepts one read or write request at a time through a valid/ready handshake and services it from an on-chip single-port RAM or a small memory-mapped I/O window.
- Returns exactly one response pulse per request after a fixed, parameterised latency.
- Sits between the CPU controller/datapath and the board switches/LEDs.

Parameters:
- DEPTH_LOG2, 10, RAM holds 2**DEPTH_LOG2 16-bit words at addresses 0 .. 2**DEPTH_LOG2-1.
- READ_LATENCY, 1, number of ACCESS cycles per request; legal range 1..8.
- IO_BASE, 16'hFF00, first address of the I/O window, which runs from IO_BASE to 16'hFFFF. Must exceed 2**DEPTH_LOG2-1.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- request_valid  input  1  a request is present on the request_* signals.
- request_ready  output  1  the block can accept a request this cycle.
- request_write  input  1  1 = write, 0 = read.
- request_address  input  16  word address.
- request_write_data  input  16  data for writes.
- response_valid  output  1  one-cycle pulse marking completion of the accepted request.
- response_read_data  output  16  read result; valid only while response_valid=1.
- io_input  input  16  external switch inputs, treated as asynchronous.
- io_output  output  16  LED output register.
- error  output  1  sticky flag for any out-of-range access.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, request_ready=0 while reset is held.
  - response_valid=0, response_read_data=0, io_output=0, error=0, latency counter=0, latched request cleared.
  - RAM contents are not reset; RAM is zero at configuration.
- States: IDLE, ACCESS, RESPOND.
- request_ready = (state==IDLE) && reset. It is combinational from state only and never depends on request_valid.
- IDLE:
  - Acceptance happens on a rising edge where request_valid && request_ready.
  - On acceptance: latch write, address and write data; counter <= READ_LATENCY-1; go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - Request inputs are ignored.
  - Counter decrements on each edge.
  - On the edge where counter==0, go to RESPOND and perform the access as described below.
- RESPOND:
  - response_valid=1 for exactly one cycle; there is no backpressure on the response.
  - Next edge returns to IDLE.
- Latency: a request accepted at edge k gives response_valid high between edges k+READ_LATENCY and k+READ_LATENCY+1. request_ready is high again after edge k+READ_LATENCY+1. With READ_LATENCY=1 the sequence is accept, 1 ACCESS cycle, 1 RESPOND cycle.
- Access decode, using the latched address A, performed on the edge ACCESS→RESPOND:
  - A < 2**DEPTH_LOG2:
    - Read: response_read_data <= RAM[A].
    - Write: RAM[A] <= data; response_read_data <= 0.
  - A == IO_BASE:
    - Read: response_read_data <= io_input. io_input is first passed through a 2-flop synchroniser that runs continuously.
    - Write: ignored; response_read_data <= 0.
  - A == IO_BASE+1:
    - Read: response_read_data <= io_output.
    - Write: io_output <= data.
  - Other addresses inside the I/O window: reads return 0, writes are ignored, error is not set.
  - 2**DEPTH_LOG2 <= A < IO_BASE (out of range): reads return 0, writes are ignored, error <= 1 (sticky until reset).
- Writes always produce a response pulse, as an acknowledgement, with read data 0.
- response_read_data holds its value after the pulse until the next access completes.
- Back-to-back requests: request_valid held high continuously is accepted every READ_LATENCY+2 cycles, with no request lost or duplicated.
- Reset asserted mid-ACCESS: the transaction is dropped, a pending write is not committed, and no response is produced.
- request_valid must stay high until accepted. Dropping it before acceptance simply cancels the request with no side effects.

Decomposition:
- Package memory_map_pkg holds:
  - State encoding constants STATE_IDLE, STATE_ACCESS, STATE_RESPOND (2 bits).
  - IO_BASE default, IO_SWITCH_OFFSET=0, IO_LED_OFFSET=1.
  - Response constant READ_DATA_NONE=16'h0000.
- Sub-module ram_single_port:
  - Parameters DEPTH_LOG2 and width 16.
  - Ports clock, write_enable, address, write_data, read_data.
  - Synchronous write, registered read, inferable as block RAM.
- The FSM, counter, address decode, synchroniser and I/O registers stay in memory_responder.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release → request_ready=1, response_valid=0, io_output=0, error=0.
- RAM write then read, READ_LATENCY=1:
  - Write 16'hBEEF to 16'h0005 → response_valid pulses 2 cycles after acceptance with read data 0.
  - Read 16'h0005 → response_read_data=16'hBEEF during the pulse.
- I/O window:
  - Write 16'h00A5 to 16'hFF01 → io_output=16'h00A5.
  - Drive io_input=16'h1234, wait 3 cycles, read 16'hFF00 → 16'h1234.
  - Read 16'hFF07 → 16'h0000 and error stays 0.
- Out of range, DEPTH_LOG2=10: write 16'h1111 to 16'h0400 → error=1, a following read of 16'h0000 is unaffected, error stays 1 until reset.
- Latency and throughput, READ_LATENCY=4: request_valid held high for 20 cycles → exactly 3 responses, each 5 cycles after its acceptance edge, request_ready low between acceptance and the end of the pulse.
- Reset mid-operation: assert reset during ACCESS of a write of 16'h7777 to 16'h0010 → no response_valid. After release, a read of 16'h0010 returns the prior contents, 16'h0000.
